div_unit_32: RTL and testbench
==============================

DIV_UNIT_32 -- requirements
Module: div_unit_32

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands and mode present.
REQ-005 SHALL have port in_ready  output  1  unit idle, can accept operands.
REQ-006 SHALL have port sign  input  1  1 = two's-complement signed divide, 0 = unsigned.
REQ-007 SHALL have port A  input  32  dividend.
REQ-008 SHALL have port B  input  32  divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port Q  output  32  quotient.
REQ-012 SHALL have port R  output  32  remainder.
REQ-013 SHALL have port DZ  output  1  divisor was zero.
REQ-014 SHALL have port OF  output  1  signed overflow (0x80000000 / -1).
REQ-015 SHALL have port ZF  output  1  Q == 0.

Function
REQ-016 SHALL implement FSM IDLE, CALC, FIX, DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept operands on a rising edge where in_valid && in_ready, registering A, B and sign.
REQ-018 SHALL, on accept with B != 0 and no overflow, go IDLE->CALC and run a restoring shift-subtract, one quotient bit per cycle, for exactly 32 CALC cycles.
REQ-019 SHALL, in signed mode, divide magnitudes and apply signs in FIX: Q negated when sign(A) != sign(B); R takes sign of A (truncating division).
REQ-020 SHALL go CALC->FIX after the 32nd iteration, FIX->DONE after one cycle; out_valid rises exactly 34 cycles after the accepting edge.
REQ-021 SHALL, on accept with B == 0, go directly to DONE next cycle with Q = 0xFFFFFFFF, R = A, DZ = 1, OF = 0.
REQ-022 SHALL, on accept with sign = 1, A = 0x80000000, B = 0xFFFFFFFF, go directly to DONE next cycle with Q = 0x80000000, R = 0, OF = 1, DZ = 0.
REQ-023 SHALL assert out_valid only in DONE and hold Q, R, DZ, OF, ZF stable until out_valid && out_ready.
REQ-024 SHALL go DONE->IDLE on out_valid && out_ready; in_ready rises the following cycle, with no same-cycle pass-through.
REQ-025 SHALL ignore in_valid while not in IDLE; operands are not latched.
REQ-026 SHALL compute ZF = (Q == 0) from the final, sign-corrected Q; ZF and the flags are meaningful only while out_valid = 1.
REQ-027 SHALL keep the 5-bit iteration counter saturating-free: it is loaded to 0 on accept and wraps never, since exit occurs at count 31.

Reset
REQ-028 SHALL, when rst_n = 0 at a rising edge, force state IDLE, Q = 0, R = 0, DZ = 0, OF = 0, ZF = 0, out_valid = 0, counter = 0; in_ready = 1 from the next cycle.
REQ-029 SHALL abort any in-flight division on reset without producing out_valid.

Configuration
REQ-030 SHALL compile the signed path only when macro DIV_UNIT_SIGNED_EN is defined: negate-in, sign fix-up, and the overflow case.
REQ-031 SHALL, without DIV_UNIT_SIGNED_EN, treat sign as don't-care, perform unsigned division only, hold OF = 0, and still traverse FIX with Q/R unchanged, keeping 34-cycle latency.

Verification
REQ-032 SHALL cover: unsigned A = 100, B = 7 -> after 34 cycles Q = 14, R = 2, ZF = 0, DZ = 0.
REQ-033 SHALL cover: signed A = 0xFFFFFFF9 (-7), B = 2 -> Q = 0xFFFFFFFD (-3), R = 0xFFFFFFFF (-1).
REQ-034 SHALL cover: A = 5, B = 0 -> out_valid 1 cycle after accept, Q = 0xFFFFFFFF, R = 5, DZ = 1.
REQ-035 SHALL cover: signed A = 0x80000000, B = 0xFFFFFFFF -> 1 cycle latency, Q = 0x80000000, R = 0, OF = 1; with DIV_UNIT_SIGNED_EN undefined -> Q = 0, R = 0x80000000, OF = 0, ZF = 1 at 34 cycles.
REQ-036 SHALL cover: A = 3, B = 9 with out_ready = 0 for 10 cycles after out_valid -> Q = 0, R = 3, ZF = 1 held stable; in_valid pulses during that window are ignored.
REQ-037 SHALL cover: rst_n = 0 for one cycle at cycle 10 of CALC -> next cycle IDLE, in_ready = 1, out_valid = 0; a new 100/7 then completes normally.

Source files
------------

// File: rtl/div_unit_32.sv
// ============================================================================
// Module      : div_unit_32
// Description : Iterative 32-bit divider. Restoring shift-subtract, one
//               quotient bit per cycle, with ready/valid handshakes on both
//               sides. Divide-by-zero and signed overflow resolve in one
//               cycle; a normal divide produces out_valid 34 cycles after
//               the accepting edge.
//               Optional feature macro: DIV_UNIT_SIGNED_EN
//                 defined   -> signed path (magnitude in, sign fix-up,
//                              0x80000000 / -1 overflow shortcut)
//                 undefined -> unsigned only, sign ignored, OF held at 0
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  / in_ready  - operand handshake (ready only idle)
//               sign      - 1 = signed divide, 0 = unsigned
//               A, B      - dividend, divisor
//               out_valid / out_ready - result handshake
//               Q, R      - quotient, remainder
//               DZ, OF, ZF- divide-by-zero, signed overflow, Q == 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             OF,
    output logic             ZF
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [4:0] c_LAST = 5'd31;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic             r_of;
    logic             r_zf;

    logic             w_accept;
    logic             w_bzero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The partial remainder
    // is below the divisor, so the shifted value needs one extra bit, but the
    // difference (when taken) always fits back into WIDTH bits.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    assign w_accept = in_valid && in_ready;
    assign w_bzero  = (B == {WIDTH{1'b0}});

`ifdef DIV_UNIT_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag = (sign && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
    assign w_b_mag = (sign && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;
    assign w_ovf   = sign && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);

    // Truncating division: quotient negative when operand signs differ,
    // remainder follows the dividend.
    assign w_q_fin = r_neg_q ? ({WIDTH{1'b0}} - r_quo) : r_quo;
    assign w_r_fin = r_neg_r ? ({WIDTH{1'b0}} - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= sign && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r <= sign && A[WIDTH-1];
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = sign;
    assign w_a_mag       = A;
    assign w_b_mag       = B;
    assign w_ovf         = 1'b0;
    assign w_q_fin       = r_quo;
    assign w_r_fin       = r_rem;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_next = (w_bzero || w_ovf) ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_next = c_FIX;
                end
            end
            c_FIX:  w_next = c_DONE;
            c_DONE: begin
                if (out_ready) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE:  in_ready  = 1'b1;
            c_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 5'd0;
            r_div <= {WIDTH{1'b0}};
            r_quo <= {WIDTH{1'b0}};
            r_rem <= {WIDTH{1'b0}};
            r_dz  <= 1'b0;
            r_of  <= 1'b0;
            r_zf  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= 5'd0;
                        r_dz  <= 1'b0;
                        r_of  <= 1'b0;
                        r_zf  <= 1'b0;
                        r_div <= w_b_mag;
                        if (w_bzero) begin
                            r_quo <= {WIDTH{1'b1}};
                            r_rem <= A;
                            r_dz  <= 1'b1;
                        end else if (w_ovf) begin
                            r_quo <= {1'b1, {(WIDTH-1){1'b0}}};
                            r_rem <= {WIDTH{1'b0}};
                            r_of  <= 1'b1;
                        end else begin
                            // r_quo doubles as the dividend shift register;
                            // quotient bits fill in from the bottom.
                            r_quo <= w_a_mag;
                            r_rem <= {WIDTH{1'b0}};
                        end
                    end
                end
                c_CALC: begin
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    if (r_cnt != c_LAST) begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_FIX: begin
                    r_quo <= w_q_fin;
                    r_rem <= w_r_fin;
                    r_zf  <= (w_q_fin == {WIDTH{1'b0}});
                end
                default: ;
            endcase
        end
    end

    assign Q  = r_quo;
    assign R  = r_rem;
    assign DZ = r_dz;
    assign OF = r_of;
    assign ZF = r_zf;

endmodule

`default_nettype wire

// File: tb/tb_div_unit_32.sv
// ============================================================================
// Module      : tb_div_unit_32
// Description : Directed self-checking bench for div_unit_32. Expected values
//               are hand-computed; signed-mode expectations switch on
//               DIV_UNIT_SIGNED_EN to match the build of the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Q;
    logic [31:0] R;
    logic        DZ;
    logic        OF;
    logic        ZF;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_unit_32 #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .DZ        (DZ),
        .OF        (OF),
        .ZF        (ZF)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency (cycles from the accepting edge
    // to the edge that first samples out_valid high), check the result,
    // optionally hold it for `hold` cycles with stray in_valid pulses, then
    // release it and confirm the return to idle.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eof, input logic ezf,
                          input int hold);
        int k;
        @(negedge clk);
        sign     = s;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        check({tag, "_ready_before"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 32'd0;
        B        = 32'd0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k + 1), 64'(exp_lat));
        check({tag, "_q"},  64'(Q),  64'(eq));
        check({tag, "_r"},  64'(R),  64'(er));
        check({tag, "_dz"}, 64'(DZ), 64'(edz));
        check({tag, "_of"}, 64'(OF), 64'(eof));
        check({tag, "_zf"}, 64'(ZF), 64'(ezf));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            A        = 32'd50;
            B        = 32'd5;
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_q"},     64'(Q),         64'(eq));
            check({tag, "_hold_r"},     64'(R),         64'(er));
            check({tag, "_hold_zf"},    64'(ZF),        64'(ezf));
            check({tag, "_hold_busy"},  64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign      = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_q",  64'(Q),  64'd0);
        check("rst_r",  64'(R),  64'd0);
        check("rst_dz", 64'(DZ), 64'd0);
        check("rst_of", 64'(OF), 64'd0);
        check("rst_zf", 64'(ZF), 64'd0);

        // Unsigned divides
        run_op("u100_7",  1'b0, 32'd100,      32'd7,       34, 32'd14,       32'd2, 1'b0, 1'b0, 1'b0, 0);
        run_op("u1e6_1e3",1'b0, 32'd1000000,  32'd1000,    34, 32'd1000,     32'd0, 1'b0, 1'b0, 1'b0, 0);
        run_op("umax_1",  1'b0, 32'hFFFFFFFF, 32'd1,       34, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        run_op("umax_max",1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,34, 32'd1,        32'd0, 1'b0, 1'b0, 1'b0, 0);

        // Signed-mode requests
`ifdef DIV_UNIT_SIGNED_EN
        run_op("s_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0);
        run_op("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 34, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op("s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000, 32'd0,        1'b0, 1'b1, 1'b0, 0);
`else
        run_op("s_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        34, 32'h7FFFFFFC, 32'd1,        1'b0, 1'b0, 1'b0, 0);
        run_op("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 34, 32'd0,        32'hFFFFFF9C, 1'b0, 1'b0, 1'b1, 0);
        run_op("s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0,        32'h80000000, 1'b0, 1'b0, 1'b1, 0);
`endif

        // Divide by zero
        run_op("dz_5_0", 1'b0, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 1'b0, 0);

        // Result held with out_ready low for 10 cycles, stray in_valid pulses
        run_op("hold_3_9", 1'b0, 32'd3, 32'd9, 34, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1, 10);
        repeat (3) begin
            @(negedge clk);
            check("hold_no_stray_op", 64'(out_valid), 64'd0);
        end

        // Reset mid-calculation
        @(negedge clk);
        sign     = 1'b0;
        A        = 32'd100;
        B        = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_q", 64'(Q), 64'd0);
        check("abort_r", 64'(R), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_result", 64'(out_valid), 64'd0);
        run_op("post_abort_100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
